beep_pattern_gen: RTL and testbench

//  Command-driven buzzer sequencer: drives the passive buzzer output, where the key path only consumes key input.

---
 rtl/beep_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_beep_pattern_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/beep_pattern_gen.sv
// beep_pattern_gen: command-driven buzzer sequencer playing N tone bursts separated by silent gaps.
// Define BEEP_ABORT_EN to add an abort input that ends a running sequence early.
module beep_pattern_gen #(
  parameter logic [23:0] ON_CNT    = 24'd5000000,
  parameter logic [23:0] OFF_CNT   = 24'd2500000,
  parameter logic [15:0] TONE_HALF = 16'd12500
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
`ifdef BEEP_ABORT_EN
  input  logic       abort,
`endif
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_count,
  input  logic [1:0] cmd_tone,
  output logic       beep,
  output logic       busy,
  output logic       done
);

  // state  | meaning
  // S_IDLE | waiting for a command, cmd_ready high
  // S_TONE | burst playing, beep toggles every half-period
  // S_GAP  | silent gap between bursts, beep held low
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_timer;
  logic [18:0] r_tone_cnt;
  logic [18:0] r_half;
  logic [18:0] w_cmd_half;
  logic [3:0]  r_bursts;
  logic        r_beep;
  logic        r_done;
  logic        w_accept;
  logic        w_abort;
  logic        w_timer_tc;
  logic        w_tone_tc;
  logic        w_last_burst;

`ifdef BEEP_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_cmd_half   = {3'b000, TONE_HALF} << cmd_tone;
  assign w_timer_tc   = (r_timer == 24'd0);
  assign w_tone_tc    = (r_tone_cnt == 19'd0);
  assign w_last_burst = (r_bursts == 4'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (cmd_count != 4'd0)) w_state_nxt = S_TONE;
      end
      S_TONE: begin
        if (w_abort)         w_state_nxt = S_IDLE;
        else if (w_timer_tc) w_state_nxt = w_last_burst ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (w_abort)         w_state_nxt = S_IDLE;
        else if (w_timer_tc) w_state_nxt = S_TONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst/gap timer and tone divider are independent down-counters; a burst may end mid-phase.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_timer    <= 24'd0;
      r_tone_cnt <= 19'd0;
      r_half     <= 19'd0;
      r_bursts   <= 4'd0;
      r_beep     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bursts <= cmd_count;
            r_half   <= w_cmd_half;
            if (cmd_count == 4'd0) begin
              r_done <= 1'b1;
            end else begin
              r_timer    <= ON_CNT - 24'd1;
              r_tone_cnt <= w_cmd_half - 19'd1;
              r_beep     <= 1'b1;
            end
          end
        end
        S_TONE: begin
          if (w_abort) begin
            r_beep <= 1'b0;
            r_done <= 1'b1;
          end else if (w_timer_tc) begin
            r_beep   <= 1'b0;
            r_bursts <= r_bursts - 4'd1;
            if (w_last_burst) r_done  <= 1'b1;
            else              r_timer <= OFF_CNT - 24'd1;
          end else begin
            r_timer <= r_timer - 24'd1;
            if (w_tone_tc) begin
              r_beep     <= ~r_beep;
              r_tone_cnt <= r_half - 19'd1;
            end else begin
              r_tone_cnt <= r_tone_cnt - 19'd1;
            end
          end
        end
        S_GAP: begin
          if (w_abort) begin
            r_done <= 1'b1;
          end else if (w_timer_tc) begin
            r_timer    <= ON_CNT - 24'd1;
            r_tone_cnt <= r_half - 19'd1;
            r_beep     <= 1'b1;
          end else begin
            r_timer <= r_timer - 24'd1;
          end
        end
        default: begin
          r_beep <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    beep      = r_beep;
    done      = r_done;
  end

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Testbench for beep_pattern_gen: scoreboard of expected per-command waveform signatures
// built from an arithmetic model of the burst/gap/tone rules, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_beep_pattern_gen;
  localparam int ON   = 20;
  localparam int OFF  = 10;
  localparam int HALF = 2;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_count = 4'd0;
  logic [1:0] cmd_tone  = 2'd0;
  logic       cmd_ready;
  logic       beep;
  logic       busy;
  logic       done;
`ifdef BEEP_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  beep_pattern_gen #(
    .ON_CNT   (24'(ON)),
    .OFF_CNT  (24'(OFF)),
    .TONE_HALF(16'(HALF))
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
`ifdef BEEP_ABORT_EN
    .abort    (abort),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_count(cmd_count),
    .cmd_tone (cmd_tone),
    .beep     (beep),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int          len;
    int          high;
    int unsigned sig;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int unsigned sig_step(int unsigned s, bit b);
    return s * 33 + (b ? 32'd2 : 32'd1);
  endfunction

  // Expected busy-window beep waveform: bursts of ON cycles, each starting high and flipping
  // every (HALF << tone) cycles, separated by OFF-cycle silent gaps; optionally cut at limit.
  function automatic exp_t model(int n, int tone, int limit);
    exp_t e;
    int   h;
    int   p;
    bit   b;
    h      = HALF << tone;
    e.len  = (n == 0) ? 0 : n * ON + (n - 1) * OFF;
    if (limit >= 0 && limit < e.len) e.len = limit;
    e.high = 0;
    e.sig  = 0;
    for (int j = 0; j < e.len; j++) begin
      p = j % (ON + OFF);
      b = (p < ON) && (((p / h) % 2) == 0);
      e.high += int'(b);
      e.sig   = sig_step(e.sig, b);
    end
    return e;
  endfunction

  // Monitor
  int          m_since = -1;
  int          m_len   = 0;
  int          m_high  = 0;
  int unsigned m_sig   = 0;
  int          m_dones = 0;

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      m_since = -1;
      m_len   = 0;
      m_high  = 0;
      m_sig   = 0;
    end else begin
      check("ready_is_not_busy", int'(cmd_ready), int'(!busy));
      if (!busy) check("beep_low_when_idle", int'(beep), 0);
      if (m_since >= 0) m_since++;
      if (busy) begin
        m_len++;
        m_high += int'(beep);
        m_sig   = sig_step(m_sig, beep);
      end
      if (done) begin
        m_dones++;
        check("done_not_busy", int'(busy), 0);
        if (exp_q.size() == 0) begin
          check("done_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", m_len, e.len);
          check("beep_high_cycles", m_high, e.high);
          check("beep_waveform_sig", int'(m_sig), int'(e.sig));
          check("done_latency", m_since, e.len + 1);
        end
        m_len   = 0;
        m_high  = 0;
        m_sig   = 0;
        m_since = -1;
      end
      if (cmd_valid && cmd_ready) m_since = 0;
    end
  end

  task automatic send(int n, int tone, bit hold, int limit);
    int waited;
    waited = 0;
    @(posedge sys_clk);
    #1;
    exp_q.push_back(model(n, tone, limit));
    cmd_count = 4'(n);
    cmd_tone  = 2'(tone);
    cmd_valid = 1'b1;
    @(negedge sys_clk);
    while (!cmd_ready && waited < 2000) begin
      @(negedge sys_clk);
      waited++;
    end
    check("accept_timeout", int'(waited < 2000), 1);
    @(posedge sys_clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(int bound);
    int k;
    k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (!done && k < bound);
    check("done_timeout", int'(done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("reset_beep", int'(beep), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ready", int'(cmd_ready), 1);

    send(3, 0, 1'b0, -1);
    wait_done(200);
    send(1, 2, 1'b0, -1);
    wait_done(100);
    send(0, 0, 1'b0, -1);
    wait_done(5);

    // cmd_valid held: second command must start right after the done cycle
    send(2, 1, 1'b1, -1);
    exp_q.push_back(model(2, 1, -1));
    wait_done(200);
    @(negedge sys_clk);
    check("b2b_second_accept", int'(busy), 1);
    cmd_valid = 1'b0;
    wait_done(200);

    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, -1);
      wait_done(1000);
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
    end

    // asynchronous reset in the middle of a burst
    send(4, 1, 1'b0, -1);
    repeat (7) @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    check("rst_mid_beep", int'(beep), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(cmd_ready), 1);
    check("rst_mid_done", int'(done), 0);
    exp_q.delete();
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    seen = m_dones;
    repeat (10) @(negedge sys_clk);
    check("no_done_after_reset", m_dones - seen, 0);

`ifdef BEEP_ABORT_EN
    // abort during the 5th gap cycle (busy index 24) of a 3-burst command
    send(3, 0, 1'b0, 25);
    repeat (25) @(negedge sys_clk);
    abort = 1'b1;
    @(posedge sys_clk);
    #1 abort = 1'b0;
    @(negedge sys_clk);
    check("abort_done", int'(done), 1);
    check("abort_beep", int'(beep), 0);
    check("abort_busy", int'(busy), 0);
    repeat (3) @(negedge sys_clk);
`endif

    check("pending_expected", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
